// File: rtl/data_memory_banked.sv
// Banked data memory for the MEM stage: byte-lane writes, configurable read latency
// with a busy stall, and a one-cycle error pulse for rejected requests.
module data_memory_banked #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4096,
   parameter int RD_LAT = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                MemRd,
   input  logic                MemWr,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic [DATA_W-1:0]   data_out,
   output logic                rd_valid,
   output logic                busy,
   output logic                err
);

   localparam int              BE_W      = DATA_W / 8;
   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
   localparam logic [2:0]      WAIT_INIT = 3'(RD_LAT - 1);

   typedef enum logic {
      IDLE,
      RD_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  rd_idx_q;
   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              idle;
   logic              in_range;
   logic              req_bad;
   logic              wr_ok;
   logic              rd_ok;
   logic              rd_fire;

   // NOTE: the array has no reset; contents must survive RST_N and a reset
   // term here would turn the RAM into a flop bank.
   logic [DATA_W-1:0] mem [DEPTH];

   // Upper address bits only matter for the range check; the index uses the low bits.
   assign idle     = (state_q == IDLE);
   assign in_range = ({1'b0, address} < DEPTH_LIM);
   assign req_idx  = address[IDX_W-1:0];
   assign req_bad  = idle & ((MemRd & MemWr) | ((MemRd | MemWr) & ~in_range));
   assign wr_ok    = idle & MemWr & ~MemRd & in_range;
   assign rd_ok    = idle & MemRd & ~MemWr & in_range;
   assign rd_idx   = idle ? req_idx : rd_idx_q;
   assign busy     = (state_q == RD_WAIT);

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_ok) begin
               if (RD_LAT == 1) begin
                  rd_fire = 1'b1;
               end else begin
                  state_d = RD_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rd_fire = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         rd_idx_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (rd_ok) rd_idx_q <= req_idx;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         data_out <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         err      <= req_bad;
         if (rd_fire) data_out <= mem[rd_idx];
      end
   end

   // Writes only happen from IDLE, so a pending read can never see a stale-vs-new race.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         for (int i = 0; i < BE_W; i++) begin
            if (byte_en[i]) mem[req_idx][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench: three instances (RD_LAT = 1, 3, 4) share clock, reset and request inputs.
module tb_data_memory_banked;

   logic        clk;
   logic        rst_n;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] address;
   logic [15:0] data_in;
   logic [1:0]  byte_en;

   logic [15:0] d1, d3, d4;
   logic        v1, v3, v4;
   logic        b1, b3, b4;
   logic        e1, e3, e4;

   int total = 0;
   int bad   = 0;

   data_memory_banked #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .RD_LAT(1)) u_lat1 (
      .CLK(clk), .RST_N(rst_n), .MemRd(mem_rd), .MemWr(mem_wr), .address(address),
      .data_in(data_in), .byte_en(byte_en), .data_out(d1), .rd_valid(v1), .busy(b1), .err(e1));

   data_memory_banked #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .RD_LAT(3)) u_lat3 (
      .CLK(clk), .RST_N(rst_n), .MemRd(mem_rd), .MemWr(mem_wr), .address(address),
      .data_in(data_in), .byte_en(byte_en), .data_out(d3), .rd_valid(v3), .busy(b3), .err(e3));

   data_memory_banked #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .RD_LAT(4)) u_lat4 (
      .CLK(clk), .RST_N(rst_n), .MemRd(mem_rd), .MemWr(mem_wr), .address(address),
      .data_in(data_in), .byte_en(byte_en), .data_out(d4), .rd_valid(v4), .busy(b4), .err(e4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      address = 16'h0000;
      data_in = 16'h0000;
      byte_en = 2'b00;
   endtask

   task automatic drive_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
      mem_rd  = 1'b0;
      mem_wr  = 1'b1;
      address = a;
      data_in = d;
      byte_en = be;
   endtask

   task automatic drive_rd(input logic [15:0] a);
      mem_rd  = 1'b1;
      mem_wr  = 1'b0;
      address = a;
      data_in = 16'h0000;
      byte_en = 2'b00;
   endtask

   task automatic drain();
      idle_in();
      repeat (5) step();
   endtask

   task automatic test_reset();
      idle_in();
      rst_n = 1'b0;
      #12;
      total++;
      if ({d1, v1, b1, e1} !== 19'd0) begin
         bad++;
         $display("FAIL reset_lat1: got d=%h v=%b b=%b e=%b, want all zero", d1, v1, b1, e1);
      end
      total++;
      if ({d4, v4, b4, e4} !== 19'd0) begin
         bad++;
         $display("FAIL reset_lat4: got d=%h v=%b b=%b e=%b, want all zero", d4, v4, b4, e4);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      drive_wr(16'h0010, 16'hBEEF, 2'b11);
      step();
      total++;
      if (v1 !== 1'b0 || e1 !== 1'b0 || b1 !== 1'b0) begin
         bad++;
         $display("FAIL wr_flags: got v=%b e=%b b=%b, want 0 0 0", v1, e1, b1);
      end
      drive_rd(16'h0010);
      step();
      total++;
      if (d1 !== 16'hBEEF || v1 !== 1'b1 || b1 !== 1'b0) begin
         bad++;
         $display("FAIL rd_beef: got d=%h v=%b b=%b, want beef 1 0", d1, v1, b1);
      end
      idle_in();
      step();
      total++;
      if (v1 !== 1'b0 || d1 !== 16'hBEEF) begin
         bad++;
         $display("FAIL rd_pulse_hold: got d=%h v=%b, want beef 0", d1, v1);
      end
      drain();
   endtask

   task automatic test_byte_lanes();
      drive_wr(16'h0005, 16'h1234, 2'b11);
      step();
      drive_wr(16'h0005, 16'hAB00, 2'b10);
      step();
      drive_wr(16'h0005, 16'hFFFF, 2'b00);
      step();
      total++;
      if (e1 !== 1'b0) begin
         bad++;
         $display("FAIL be_zero_err: got err=%b, want 0", e1);
      end
      drive_rd(16'h0005);
      step();
      total++;
      if (d1 !== 16'hAB34 || v1 !== 1'b1) begin
         bad++;
         $display("FAIL byte_merge: got d=%h v=%b, want ab34 1", d1, v1);
      end
      drain();
   endtask

   task automatic test_lat3();
      drive_wr(16'h0020, 16'h5A5A, 2'b11);
      step();
      drive_rd(16'h0020);
      step();                              // edge T
      total++;
      if (b3 !== 1'b1 || v3 !== 1'b0) begin
         bad++;
         $display("FAIL lat3_t0: got b=%b v=%b, want 1 0", b3, v3);
      end
      drive_wr(16'h0020, 16'hFFFF, 2'b11);
      step();                              // edge T+1
      total++;
      if (b3 !== 1'b1 || v3 !== 1'b0) begin
         bad++;
         $display("FAIL lat3_t1: got b=%b v=%b, want 1 0", b3, v3);
      end
      step();                              // edge T+2
      total++;
      if (b3 !== 1'b0 || v3 !== 1'b1 || d3 !== 16'h5A5A) begin
         bad++;
         $display("FAIL lat3_t2: got b=%b v=%b d=%h, want 0 1 5a5a", b3, v3, d3);
      end
      idle_in();
      step();                              // edge T+3
      total++;
      if (b3 !== 1'b0 || v3 !== 1'b0) begin
         bad++;
         $display("FAIL lat3_t3: got b=%b v=%b, want 0 0", b3, v3);
      end
      drive_rd(16'h0020);
      step();
      idle_in();
      step();
      step();
      total++;
      if (v3 !== 1'b1 || d3 !== 16'h5A5A) begin
         bad++;
         $display("FAIL lat3_no_wr_busy: got v=%b d=%h, want 1 5a5a", v3, d3);
      end
      drain();
   endtask

   task automatic test_errors();
      drive_wr(16'h0030, 16'h1111, 2'b11);
      step();
      mem_rd  = 1'b1;
      mem_wr  = 1'b1;
      address = 16'h0030;
      data_in = 16'h7777;
      byte_en = 2'b11;
      step();
      total++;
      if (e1 !== 1'b1 || v1 !== 1'b0) begin
         bad++;
         $display("FAIL both_err: got e=%b v=%b, want 1 0", e1, v1);
      end
      idle_in();
      step();
      total++;
      if (e1 !== 1'b0) begin
         bad++;
         $display("FAIL err_pulse: got e=%b, want 0", e1);
      end
      drive_rd(16'h0030);
      step();
      total++;
      if (d1 !== 16'h1111 || v1 !== 1'b1) begin
         bad++;
         $display("FAIL both_no_write: got d=%h v=%b, want 1111 1", d1, v1);
      end
      drain();
      drive_rd(16'h1000);
      step();
      total++;
      if (e1 !== 1'b1 || v1 !== 1'b0 || d1 !== 16'h1111) begin
         bad++;
         $display("FAIL oor_lat1: got e=%b v=%b d=%h, want 1 0 1111", e1, v1, d1);
      end
      total++;
      if (e3 !== 1'b1 || b3 !== 1'b0) begin
         bad++;
         $display("FAIL oor_lat3: got e=%b b=%b, want 1 0", e3, b3);
      end
      idle_in();
      step();
      total++;
      if (e1 !== 1'b0 || v1 !== 1'b0) begin
         bad++;
         $display("FAIL oor_after: got e=%b v=%b, want 0 0", e1, v1);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) begin
         drive_wr(16'(i), 16'hC000 + 16'(i * 16'h0111), 2'b11);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         drive_rd(16'(i));
         step();
         exp = 16'hC000 + 16'(i * 16'h0111);
         total++;
         if (v1 !== 1'b1 || d1 !== exp) begin
            bad++;
            $display("FAIL b2b_%0d: got v=%b d=%h, want 1 %h", i, v1, d1, exp);
         end
      end
      idle_in();
      step();
      total++;
      if (v1 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: got v=%b, want 0", v1);
      end
      drain();
   endtask

   task automatic test_reset_mid_wait();
      drive_wr(16'h0040, 16'h4242, 2'b11);
      step();
      drive_rd(16'h0040);
      step();
      idle_in();
      step();
      total++;
      if (b4 !== 1'b1 || v4 !== 1'b0) begin
         bad++;
         $display("FAIL lat4_waiting: got b=%b v=%b, want 1 0", b4, v4);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (b4 !== 1'b0 || v4 !== 1'b0 || d4 !== 16'h0000) begin
         bad++;
         $display("FAIL async_reset: got b=%b v=%b d=%h, want 0 0 0000", b4, v4, d4);
      end
      #2;
      rst_n = 1'b1;
      repeat (3) begin
         step();
         total++;
         if (v4 !== 1'b0 || b4 !== 1'b0) begin
            bad++;
            $display("FAIL aborted_read: got v=%b b=%b, want 0 0", v4, b4);
         end
      end
      drive_rd(16'h0040);
      step();
      idle_in();
      step();
      step();
      total++;
      if (v4 !== 1'b0 || b4 !== 1'b1) begin
         bad++;
         $display("FAIL lat4_t2: got v=%b b=%b, want 0 1", v4, b4);
      end
      step();
      total++;
      if (v4 !== 1'b1 || d4 !== 16'h4242 || b4 !== 1'b0) begin
         bad++;
         $display("FAIL lat4_kept: got v=%b d=%h b=%b, want 1 4242 0", v4, d4, b4);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_lat3();
      test_errors();
      test_back_to_back();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
